// File: rtl/smac_result_drain.sv
// Result drain at the south end of a systolic smac column: buffers res_mac_n words
// with their precision/FP tag and serializes them one packed lane per beat.
module smac_result_drain #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                        clk,
    input  logic                        aresetn,
    input  logic                        sclr,
    input  logic                        in_valid,
    input  logic [63:0]                 in_data,
    input  logic [3:0]                  select_precision,
    input  logic [1:0]                  enable_fp_unit,
    output logic [63:0]                 out_data,
    output logic [2:0]                  out_lane,
    output logic                        out_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        fifo_full,
    output logic                        overflow,
    output logic [CNT_W-1:0]            drop_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [3:0] PREC_INT8  = 4'b0001;
    localparam logic [3:0] PREC_INT16 = 4'b0010;
    localparam logic [3:0] PREC_INT32 = 4'b0100;

    typedef enum logic {
        ST_IDLE,
        ST_EMIT
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [63:0]      r_mem_data [FIFO_DEPTH];
    logic [3:0]       r_mem_prec [FIFO_DEPTH];
    logic             r_mem_fp   [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             r_head_aged;

    logic [63:0]      r_word;
    logic [3:0]       r_prec;
    logic             r_fp;
    logic [2:0]       r_lane;

    logic             r_overflow;
    logic [CNT_W-1:0] r_drop_count;

    logic             w_full;
    logic             w_push;
    logic             w_drop;
    logic             w_pop;
    logic             w_lane_inc;
    logic             w_fire;
    logic             w_emit;
    logic [2:0]       w_last_idx;
    logic             w_is_last;
    logic [7:0]       w_b8;
    logic [15:0]      w_b16;
    logic [31:0]      w_b32;
    logic [63:0]      w_ext;

    assign w_full = (r_level == LVL_W'(FIFO_DEPTH));
    // A push that finds the FIFO full is dropped even if a pop frees a slot at the same edge.
    assign w_push = in_valid & ~w_full;
    assign w_drop = in_valid & w_full;
    assign w_emit = (r_state == ST_EMIT);
    assign w_fire = w_emit & out_ready;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        w_last_idx = 3'd0;
        case (r_prec)
            PREC_INT8:  w_last_idx = 3'd7;
            PREC_INT16: w_last_idx = 3'd3;
            PREC_INT32: w_last_idx = 3'd1;
            default:    w_last_idx = 3'd0;
        endcase
    end

    assign w_is_last = (r_lane == w_last_idx);

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_lane_inc  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // The head must have sat in the FIFO for a full cycle before IDLE takes it.
                if (r_level != '0 && r_head_aged) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (w_fire) begin
                    if (!w_is_last) begin
                        w_lane_inc = 1'b1;
                    end else if (r_level != '0) begin
                        w_pop = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= ST_IDLE;
            r_word  <= '0;
            r_prec  <= '0;
            r_fp    <= 1'b0;
            r_lane  <= '0;
        end else if (sclr) begin
            r_state <= ST_IDLE;
            r_word  <= '0;
            r_prec  <= '0;
            r_fp    <= 1'b0;
            r_lane  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pop) begin
                r_word <= r_mem_data[r_rd_ptr];
                r_prec <= r_mem_prec[r_rd_ptr];
                r_fp   <= r_mem_fp[r_rd_ptr];
                r_lane <= '0;
            end else if (w_lane_inc) begin
                r_lane <= r_lane + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_head_aged <= 1'b0;
        end else if (sclr) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_head_aged <= 1'b0;
        end else begin
            r_head_aged <= (r_level != '0);
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // NOTE: storage is not reset; r_level alone says which entries hold valid words.
    always_ff @(posedge clk) begin
        if (w_push && !sclr) begin
            r_mem_data[r_wr_ptr] <= in_data;
            r_mem_prec[r_wr_ptr] <= select_precision;
            r_mem_fp[r_wr_ptr]   <= |enable_fp_unit;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (sclr) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_count != '1) r_drop_count <= r_drop_count + CNT_W'(1);
        end
    end

    assign w_b8  = r_word[{r_lane, 3'b000} +: 8];
    assign w_b16 = r_word[{r_lane[1:0], 4'b0000} +: 16];
    assign w_b32 = r_word[{r_lane[0], 5'b00000} +: 32];

    // FP lanes are zero-extended so raw FP bits pass through; integer lanes are sign-extended.
    always_comb begin
        w_ext = r_word;
        case (r_prec)
            PREC_INT8:  w_ext = r_fp ? {56'd0, w_b8}  : {{56{w_b8[7]}}, w_b8};
            PREC_INT16: w_ext = r_fp ? {48'd0, w_b16} : {{48{w_b16[15]}}, w_b16};
            PREC_INT32: w_ext = r_fp ? {32'd0, w_b32} : {{32{w_b32[31]}}, w_b32};
            default:    w_ext = r_word;
        endcase
    end

    assign out_valid  = w_emit;
    assign out_data   = w_emit ? w_ext : '0;
    assign out_lane   = w_emit ? r_lane : '0;
    assign out_last   = w_emit & w_is_last;
    assign fifo_level = r_level;
    assign fifo_full  = w_full;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

endmodule

// File: tb/tb_smac_result_drain.sv
// Bench for smac_result_drain: queue-level model compared every cycle, plus
// directed vectors with hand-computed lane values.
module tb_smac_result_drain;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic              clk = 1'b0;
    logic              aresetn = 1'b1;
    logic              sclr = 1'b0;
    logic              in_valid = 1'b0;
    logic [63:0]       in_data = '0;
    logic [3:0]        select_precision = '0;
    logic [1:0]        enable_fp_unit = '0;
    logic              out_ready = 1'b0;
    logic [63:0]       out_data;
    logic [2:0]        out_lane;
    logic              out_last;
    logic              out_valid;
    logic [2:0]        fifo_level;
    logic              fifo_full;
    logic              overflow;
    logic [CNT_W-1:0]  drop_count;

    int n_checks = 0;
    int n_fail   = 0;

    smac_result_drain #(.FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .aresetn          (aresetn),
        .sclr             (sclr),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .select_precision (select_precision),
        .enable_fp_unit   (enable_fp_unit),
        .out_data         (out_data),
        .out_lane         (out_lane),
        .out_last         (out_last),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .fifo_level       (fifo_level),
        .fifo_full        (fifo_full),
        .overflow         (overflow),
        .drop_count       (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [63:0] data;
        logic [3:0]  prec;
        logic        fp;
        int          t;
    } word_t;

    typedef struct {
        logic [63:0] data;
        logic [2:0]  lane;
        logic        last;
    } beat_t;

    word_t mq[$];
    word_t m_cur;
    logic  m_emit = 1'b0;
    int    m_idx = 0;
    logic  m_ovf = 1'b0;
    int    m_drops = 0;
    int    cyc = 0;
    beat_t got[$];

    function automatic int lanes(input logic [3:0] p);
        case (p)
            4'b0001: return 8;
            4'b0010: return 4;
            4'b0100: return 2;
            default: return 1;
        endcase
    endfunction

    function automatic logic [63:0] lane_val(input word_t w, input int idx);
        int          wd;
        logic [63:0] mask;
        logic [63:0] v;
        wd   = 64 / lanes(w.prec);
        mask = (wd == 64) ? '1 : ((64'd1 << wd) - 64'd1);
        v    = (w.data >> (idx * wd)) & mask;
        if (!w.fp && wd < 64 && v[wd-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic model_clear();
        mq.delete();
        m_emit  = 1'b0;
        m_idx   = 0;
        m_ovf   = 1'b0;
        m_drops = 0;
    endtask

    always @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            model_clear();
        end else if (sclr) begin
            model_clear();
            cyc++;
        end else begin
            bit full;
            bit pop;
            full = (mq.size() == DEPTH);
            pop  = 1'b0;
            if (!m_emit) begin
                pop = (mq.size() > 0) && (cyc - mq[0].t >= 2);
            end else if (out_ready) begin
                if (m_idx == lanes(m_cur.prec) - 1) begin
                    if (mq.size() > 0) pop = 1'b1;
                    else m_emit = 1'b0;
                end else begin
                    m_idx++;
                end
            end
            if (pop) begin
                m_cur  = mq.pop_front();
                m_idx  = 0;
                m_emit = 1'b1;
            end
            if (in_valid) begin
                if (full) begin
                    m_ovf = 1'b1;
                    if (m_drops < (1 << CNT_W) - 1) m_drops++;
                end else begin
                    mq.push_back('{in_data, select_precision, (enable_fp_unit != 2'b00), cyc});
                end
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        check("out_valid",  {63'd0, out_valid}, {63'd0, m_emit});
        check("out_data",   out_data, m_emit ? lane_val(m_cur, m_idx) : 64'd0);
        check("out_lane",   64'(out_lane), m_emit ? 64'(m_idx) : 64'd0);
        check("out_last",   {63'd0, out_last},
              {63'd0, (m_emit && m_idx == lanes(m_cur.prec) - 1)});
        check("fifo_level", 64'(fifo_level), 64'(mq.size()));
        check("fifo_full",  {63'd0, fifo_full}, {63'd0, (mq.size() == DEPTH)});
        check("overflow",   {63'd0, overflow}, {63'd0, m_ovf});
        check("drop_count", 64'(drop_count), 64'(m_drops));
        if (out_valid && out_ready && aresetn && !sclr)
            got.push_back('{out_data, out_lane, out_last});
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [63:0] d, input logic [3:0] p, input logic [1:0] f);
        in_valid         = 1'b1;
        in_data          = d;
        select_precision = p;
        enable_fp_unit   = f;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_beats(input string name, input int n, input int budget);
        int waited;
        waited = 0;
        while (got.size() < n && waited < budget) begin
            tick();
            waited++;
        end
        check(name, 64'(got.size()), 64'(n));
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] e2 [4];
        logic [63:0] e3 [4];
        logic [63:0] w5 [6];
        int          w;

        e2 = '{64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_0000_0002,
               64'h0000_0000_0000_7FFF, 64'hFFFF_FFFF_FFFF_8001};
        e3 = '{64'h0000_0000_0000_FFFE, 64'h0000_0000_0000_0002,
               64'h0000_0000_0000_7FFF, 64'h0000_0000_0000_8001};
        for (int i = 0; i < 6; i++) w5[i] = 64'hA5A5_0000_0000_0000 + 64'(i);

        #1 aresetn = 1'b0;
        repeat (3) tick();
        aresetn = 1'b1;
        tick();
        check("rst_valid", {63'd0, out_valid}, 64'd0);
        check("rst_data",  out_data, 64'd0);
        check("rst_level", 64'(fifo_level), 64'd0);
        check("rst_ovf",   {63'd0, overflow}, 64'd0);

        // INT64 single beat and push-to-valid latency
        out_ready = 1'b1;
        got.delete();
        push(64'hCAFE_CAFE_CAFE_CAFE, 4'b1000, 2'd0);
        check("t1_lat_k0", {63'd0, out_valid}, 64'd0);
        tick();
        check("t1_lat_k1", {63'd0, out_valid}, 64'd0);
        tick();
        check("t1_lat_k2", {63'd0, out_valid}, 64'd1);
        check("t1_data",   out_data, 64'hCAFE_CAFE_CAFE_CAFE);
        check("t1_lane",   64'(out_lane), 64'd0);
        check("t1_last",   {63'd0, out_last}, 64'd1);
        repeat (3) tick();
        check("t1_beats",  64'(got.size()), 64'd1);

        // INT16 integer: sign extension
        got.delete();
        push(64'h8001_7FFF_0002_FFFE, 4'b0010, 2'd0);
        wait_beats("t2_timeout", 4, 20);
        if (got.size() >= 4)
            for (int i = 0; i < 4; i++) begin
                check($sformatf("t2_data%0d", i), got[i].data, e2[i]);
                check($sformatf("t2_last%0d", i), {63'd0, got[i].last}, {63'd0, (i == 3)});
            end

        // INT16 FP: zero extension
        got.delete();
        push(64'h8001_7FFF_0002_FFFE, 4'b0010, 2'd3);
        wait_beats("t3_timeout", 4, 20);
        if (got.size() >= 4)
            for (int i = 0; i < 4; i++) check($sformatf("t3_data%0d", i), got[i].data, e3[i]);

        // INT8 with backpressure at lane 2
        got.delete();
        push(64'h0102_0304_0506_0708, 4'b0001, 2'd0);
        w = 0;
        while (!(out_valid && out_lane == 3'd2) && w < 20) begin
            tick();
            w++;
        end
        out_ready = 1'b0;
        check("t4_reach_lane2", 64'(out_lane), 64'd2);
        repeat (3) begin
            tick();
            check("t4_stall_valid", {63'd0, out_valid}, 64'd1);
            check("t4_stall_data",  out_data, 64'h06);
            check("t4_stall_lane",  64'(out_lane), 64'd2);
        end
        out_ready = 1'b1;
        wait_beats("t4_timeout", 8, 30);
        if (got.size() >= 8)
            for (int i = 0; i < 8; i++) begin
                check($sformatf("t4_data%0d", i), got[i].data, 64'(8 - i));
                check($sformatf("t4_lane%0d", i), 64'(got[i].lane), 64'(i));
            end

        // overflow: 6 pushes into a stalled drain
        out_ready = 1'b0;
        got.delete();
        for (int i = 0; i < 6; i++) begin
            in_valid         = 1'b1;
            in_data          = w5[i];
            select_precision = 4'b1000;
            enable_fp_unit   = 2'd0;
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("t5_full",  {63'd0, fifo_full}, 64'd1);
        check("t5_level", 64'(fifo_level), 64'd4);
        check("t5_ovf",   {63'd0, overflow}, 64'd1);
        check("t5_drops", 64'(drop_count), 64'd1);
        out_ready = 1'b1;
        wait_beats("t5_timeout", 5, 40);
        repeat (3) tick();
        check("t5_beats", 64'(got.size()), 64'd5);
        if (got.size() >= 5)
            for (int i = 0; i < 5; i++) check($sformatf("t5_word%0d", i), got[i].data, w5[i]);

        // synchronous clear of sticky status
        sclr = 1'b1;
        tick();
        sclr = 1'b0;
        check("sclr_ovf",   {63'd0, overflow}, 64'd0);
        check("sclr_drops", 64'(drop_count), 64'd0);
        check("sclr_level", 64'(fifo_level), 64'd0);

        // async reset in the middle of an INT32 word
        got.delete();
        push(64'h8000_0001_7FFF_FFFF, 4'b0100, 2'd0);
        w = 0;
        while (!out_valid && w < 20) begin
            tick();
            w++;
        end
        tick();
        check("t6_lane1", 64'(out_lane), 64'd1);
        aresetn = 1'b0;
        #1;
        check("t6_rst_valid", {63'd0, out_valid}, 64'd0);
        check("t6_rst_data",  out_data, 64'd0);
        check("t6_rst_lane",  64'(out_lane), 64'd0);
        check("t6_rst_last",  {63'd0, out_last}, 64'd0);
        #1 aresetn = 1'b1;
        repeat (4) tick();
        check("t6_idle_valid", {63'd0, out_valid}, 64'd0);
        check("t6_beats", 64'(got.size()), 64'd1);
        if (got.size() >= 1) check("t6_lane0_data", got[0].data, 64'h0000_0000_7FFF_FFFF);
        push(64'h0000_0000_0000_1234, 4'b1000, 2'd1);
        wait_beats("t6_resume_timeout", 2, 10);
        if (got.size() >= 2) check("t6_resume_data", got[1].data, 64'h1234);

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
